// File: rtl/dmem_lsu_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
// Covers funct3 encodings, FSM states, fault codes and store lane formatting.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        FAULT_OK       = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_ILLEGAL  = 2'b10,
        FAULT_TIMEOUT  = 2'b11
    } lsu_fault_e;

    function automatic logic is_illegal(input logic write, input logic [2:0] f3);
        if (write)
            return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        return (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    endfunction

    // Access size is carried in funct3[1:0] for every legal encoding.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return lo[0];
            2'b10:   return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_B:    return 4'b0001 << lo;
            F3_H:    return lo[1] ? 4'b1100 : 4'b0011;
            F3_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        case (f3)
            F3_B:    return {4{wd[7:0]}};
            F3_H:    return {2{wd[15:0]}};
            F3_W:    return wd;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface dmem_lsu_if #(
    parameter int unsigned XLEN = 32
);
    logic            valid;
    logic            write;
    logic [3:0]      wstrb;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rdata;
    logic            ready;

    modport master (
        output valid, write, wstrb, addr, wdata,
        input  rdata, ready
    );

    modport slave (
        input  valid, write, wstrb, addr, wdata,
        output rdata, ready
    );
endinterface

// File: rtl/dmem_lsu_load_align.sv
// Load lane select and sign/zero extension of a returned bus word.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[7:0];
        case (addr_lo)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = rdata;
        case (funct3)
            F3_B:    data = {{(XLEN-8){lane_b[7]}}, lane_b};
            F3_BU:   data = {{(XLEN-8){1'b0}}, lane_b};
            F3_H:    data = {{(XLEN-16){lane_h[15]}}, lane_h};
            F3_HU:   data = {{(XLEN-16){1'b0}}, lane_h};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: validates one pipeline request, runs a single bus
// transaction with a watchdog, and returns extended load data or a fault.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            busy,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic [1:0]      resp_fault,
    dmem_lsu_if.master      dmem
);
    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    lsu_state_e      state_q, state_d;
    lsu_fault_e      fault_q, fault_d;
    logic [CW-1:0]   cnt_q;
    logic            write_q;
    logic [3:0]      wstrb_q;
    logic [XLEN-1:0] addr_q, wdata_q, rdata_q, load_data;
    logic [2:0]      f3_q;
    logic [1:0]      lo_q;
    logic            accept_bus, accept_fault, bus_done, bus_timeout;

    always_comb begin
        state_d      = state_q;
        fault_d      = FAULT_OK;
        accept_bus   = 1'b0;
        accept_fault = 1'b0;
        bus_done     = 1'b0;
        bus_timeout  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (is_illegal(req_write, req_funct3)) begin
                        fault_d      = FAULT_ILLEGAL;
                        accept_fault = 1'b1;
                        state_d      = RESP;
                    end else if (is_misaligned(req_funct3, req_addr[1:0])) begin
                        fault_d      = FAULT_MISALIGN;
                        accept_fault = 1'b1;
                        state_d      = RESP;
                    end else begin
                        accept_bus = 1'b1;
                        state_d    = BUS;
                    end
                end
            end
            BUS: begin
                // Ready wins over an expiring watchdog in the same cycle.
                if (dmem.ready) begin
                    bus_done = 1'b1;
                    state_d  = RESP;
                end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
                    bus_timeout = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            write_q <= 1'b0;
            wstrb_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
            fault_q <= FAULT_OK;
        end else begin
            if (state_q == BUS)
                cnt_q <= cnt_q + 1'b1;
            if (accept_bus) begin
                cnt_q   <= '0;
                write_q <= req_write;
                wstrb_q <= req_write ? store_strb(req_funct3, req_addr[1:0]) : 4'b0000;
                addr_q  <= {req_addr[XLEN-1:2], 2'b00};
                wdata_q <= req_write ? store_data(req_funct3, req_wdata) : '0;
                f3_q    <= req_funct3;
                lo_q    <= req_addr[1:0];
            end
            if (accept_fault) begin
                rdata_q <= '0;
                fault_q <= fault_d;
            end
            if (bus_done) begin
                rdata_q <= write_q ? '0 : load_data;
                fault_q <= FAULT_OK;
            end
            if (bus_timeout) begin
                rdata_q <= '0;
                fault_q <= FAULT_TIMEOUT;
            end
        end
    end

    lsu_load_align #(.XLEN(XLEN)) u_align (
        .rdata   (dmem.rdata),
        .addr_lo (lo_q),
        .funct3  (f3_q),
        .data    (load_data)
    );

    assign busy       = (state_q != IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q;

    assign dmem.valid = (state_q == BUS);
    assign dmem.write = write_q;
    assign dmem.wstrb = wstrb_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a response scoreboard and a TIMEOUT=8 watchdog.
module tb_dmem_lsu;
    logic        clk;
    logic        rst;
    logic        req_valid, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        busy, resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  fault;
    } exp_t;
    exp_t sb[$];

    dmem_lsu_if #(.XLEN(32)) dmem ();

    dmem_lsu #(.XLEN(32), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .dmem       (dmem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_fault", resp_fault, e.fault);
            end
        end
    end

    // w < 0 means ready is never given; exp_bus = {write, wstrb, addr, wdata}.
    task automatic do_req(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input int w,
                          input logic [31:0] rd, input logic [31:0] exp_rd,
                          input logic [1:0] exp_fault, input logic [68:0] exp_bus,
                          input int exp_v, input int exp_lat);
        int n;
        int vcnt;
        exp_t e;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        dmem.ready = 1'b0;
        e.rdata = exp_rd;
        e.fault = exp_fault;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        n    = 1;
        vcnt = 0;
        while (!resp_valid && n < 40) begin
            chk({tag, "_busy"}, busy, 1);
            if (dmem.valid) begin
                vcnt++;
                chk({tag, "_bus"}, {dmem.write, dmem.wstrb, dmem.addr, dmem.wdata}, exp_bus);
            end
            if (w >= 0 && n == 1 + w) begin
                dmem.ready = 1'b1;
                dmem.rdata = rd;
            end
            @(negedge clk);
            n++;
        end
        dmem.ready = 1'b0;
        dmem.rdata = 32'h0BAD_0BAD;
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_valid_cycles"}, vcnt, exp_v);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        dmem.ready = 1'b0;
        dmem.rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_dmem_ctrl", {dmem.valid, dmem.write, dmem.wstrb}, 0);
        chk("rst_resp_data", {resp_rdata, resp_fault}, 0);
        chk("rst_dmem_data", {dmem.addr, dmem.wdata}, 0);
        rst = 1'b0;

        do_req("sw",  1, 3'b010, 32'h104, 32'hDEADBEEF, 2, 32'h0, 32'h0, 2'b00,
               {1'b1, 4'b1111, 32'h104, 32'hDEADBEEF}, 3, 4);
        do_req("sb",  1, 3'b000, 32'h203, 32'h000000A5, 0, 32'h0, 32'h0, 2'b00,
               {1'b1, 4'b1000, 32'h200, 32'hA5A5A5A5}, 1, 2);
        do_req("sh",  1, 3'b001, 32'h302, 32'h1234ABCD, 1, 32'h0, 32'h0, 2'b00,
               {1'b1, 4'b1100, 32'h300, 32'hABCDABCD}, 2, 3);
        do_req("lb",  0, 3'b000, 32'h302, 32'h0, 0, 32'h80FF7F01, 32'hFFFFFFFF, 2'b00,
               {1'b0, 4'b0000, 32'h300, 32'h0}, 1, 2);
        do_req("lbu", 0, 3'b100, 32'h301, 32'h0, 0, 32'h80FF7F01, 32'h0000007F, 2'b00,
               {1'b0, 4'b0000, 32'h300, 32'h0}, 1, 2);
        do_req("lh",  0, 3'b001, 32'h302, 32'h0, 3, 32'h80FF7F01, 32'hFFFF80FF, 2'b00,
               {1'b0, 4'b0000, 32'h300, 32'h0}, 4, 5);
        do_req("lhu", 0, 3'b101, 32'h302, 32'h0, 0, 32'h80FF7F01, 32'h000080FF, 2'b00,
               {1'b0, 4'b0000, 32'h300, 32'h0}, 1, 2);
        do_req("lw_mis", 0, 3'b010, 32'h106, 32'h0, 0, 32'h0, 32'h0, 2'b01, '0, 0, 1);
        do_req("sh_mis", 1, 3'b001, 32'h101, 32'h5555, 0, 32'h0, 32'h0, 2'b01, '0, 0, 1);
        do_req("ld_ill", 0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 32'h0, 2'b10, '0, 0, 1);
        do_req("st_ill", 1, 3'b100, 32'h100, 32'h0, 0, 32'h0, 32'h0, 2'b10, '0, 0, 1);
        do_req("lw",  0, 3'b010, 32'h300, 32'h0, 0, 32'h80FF7F01, 32'h80FF7F01, 2'b00,
               {1'b0, 4'b0000, 32'h300, 32'h0}, 1, 2);
        do_req("tmo", 0, 3'b010, 32'h400, 32'h0, -1, 32'h0, 32'h0, 2'b11,
               {1'b0, 4'b0000, 32'h400, 32'h0}, 8, 9);
        do_req("rdy8", 0, 3'b010, 32'h404, 32'h0, 7, 32'h12345678, 32'h12345678, 2'b00,
               {1'b0, 4'b0000, 32'h404, 32'h0}, 8, 9);

        // Reset in the middle of a bus cycle: no response may follow.
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h500;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", dmem.valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", dmem.valid, 0);
        chk("async_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_no_resp", resp_valid, 0);
            @(negedge clk);
        end

        do_req("sw_after_rst", 1, 3'b010, 32'h508, 32'hCAFEF00D, 1, 32'h0, 32'h0, 2'b00,
               {1'b1, 4'b1111, 32'h508, 32'hCAFEF00D}, 2, 3);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "bench did not complete");
    end
endmodule
